// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_MUL = 3'b101,
    OP_LSL = 3'b110,
    OP_LSR = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ADD/SUB/AND/ORR/EOR datapath with NZCV flag generation.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_op_t              op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     result_c,
  output logic [FLAG_W-1:0]    flags_c
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SW  = WIDTH + 1;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;

  // Shared adder (SUB is a + ~b + 1) and logic-op result select
  always_comb begin
    b_eff    = (op == OP_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + SW'(op == OP_SUB);
    result_c = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result_c = sum[MSB:0];
        carry    = sum[WIDTH];
        ovf      = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]);
      end
      OP_AND:  result_c = a & b;
      OP_ORR:  result_c = a | b;
      OP_EOR:  result_c = a ^ b;
      default: result_c = '0;
    endcase
    flags_c         = '0;
    flags_c[FLAG_N] = result_c[MSB];
    flags_c[FLAG_Z] = (result_c == '0);
    flags_c[FLAG_C] = carry;
    flags_c[FLAG_V] = ovf;
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU holding one operation in flight; MUL and shifts iterate one bit per cycle.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ALUControl,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  Result,
  output logic [3:0]        ALUFlags
);

  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned MSB = WIDTH - 1;

  state_t            state_q, state_d;
  alu_op_t           op_q, op_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  result_d;
  logic [3:0]        flags_d;
  logic              in_ready_d;
  logic              out_valid_d;

  alu_op_t           core_op;
  logic [WIDTH-1:0]  core_a;
  logic [WIDTH-1:0]  core_b;
  logic [WIDTH-1:0]  core_result;
  logic [3:0]        core_flags;
  logic [SHW-1:0]    shamt;
  logic [WIDTH-1:0]  shifted;
  logic              shout;

  function automatic logic [3:0] nzc_flags(input logic [WIDTH-1:0] r, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[MSB];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    return f;
  endfunction

  // Adder is shared: decoded op in IDLE, accumulate step while BUSY
  always_comb begin
    core_op = alu_op_t'(ALUControl);
    core_a  = a;
    core_b  = b;
    if (state_q == BUSY) begin
      core_op = OP_ADD;
      core_a  = acc_q;
      core_b  = opa_q;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (core_op),
    .a        (core_a),
    .b        (core_b),
    .result_c (core_result),
    .flags_c  (core_flags)
  );

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      count_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      Result    <= '0;
      ALUFlags  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      Result    <= result_d;
      ALUFlags  <= flags_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state, iteration step and registered-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = Result;
    flags_d  = ALUFlags;
    shamt    = b[SHW-1:0];
    shifted  = (op_q == OP_LSL) ? (opa_q << 1) : (opa_q >> 1);
    shout    = (op_q == OP_LSL) ? opa_q[MSB] : opa_q[0];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = alu_op_t'(ALUControl);
          opa_d = a;
          opb_d = b;
          acc_d = '0;
          case (alu_op_t'(ALUControl))
            OP_MUL: begin
              state_d = BUSY;
              count_d = CW'(WIDTH);
            end
            OP_LSL, OP_LSR: begin
              if (shamt == '0) begin
                state_d  = DONE;
                result_d = a;
                flags_d  = nzc_flags(a, 1'b0);
              end else begin
                state_d = BUSY;
                count_d = CW'(shamt);
              end
            end
            default: begin
              state_d  = DONE;
              result_d = core_result;
              flags_d  = core_flags;
            end
          endcase
        end
      end
      BUSY: begin
        count_d = count_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = opb_q[0] ? core_result : acc_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          if (count_q == CW'(1)) begin
            state_d  = DONE;
            result_d = acc_d;
            flags_d  = nzc_flags(acc_d, 1'b0);
          end
        end else begin
          opa_d = shifted;
          if (count_q == CW'(1)) begin
            state_d  = DONE;
            result_d = shifted;
            flags_d  = nzc_flags(shifted, shout);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed checks for seq_alu at WIDTH=32, plus a WIDTH=8 sweep against a reference model.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b, res;
  logic [3:0]  flags;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  flags8;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .Result(res), .ALUFlags(flags)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .ALUControl(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .Result(res8), .ALUFlags(flags8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, wait (bounded) for out_valid; lat counts edges from accept
  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busy, output logic [31:0] r, output logic [3:0] f);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    r = res; f = flags;
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output logic [7:0] r, output logic [3:0] f);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    r = res8; f = flags8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if ({res, flags} !== 36'h0) begin bad++; $display("FAIL reset_result: got %h/%b want 0/0000", res, flags); end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    int lat, busy; logic [31:0] r; logic [3:0] f;
    run32(3'b000, 32'hFFFFFFFF, 32'h00000001, lat, busy, r, f);
    total++; if (lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
    total++; if (r !== 32'h0) begin bad++; $display("FAIL add_result: got %h want 00000000", r); end
    total++; if (f !== 4'b0110) begin bad++; $display("FAIL add_flags: got %b want 0110", f); end
    run32(3'b001, 32'h7FFFFFFF, 32'hFFFFFFFF, lat, busy, r, f);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL sub_result: got %h want 80000000", r); end
    total++; if (f !== 4'b1001) begin bad++; $display("FAIL sub_flags: got %b want 1001", f); end
    run32(3'b010, 32'hF0F0FFFF, 32'h0FF00000, lat, busy, r, f);
    total++; if ({r, f} !== {32'h00F00000, 4'b0000}) begin bad++; $display("FAIL and_result: got %h/%b want 00f00000/0000", r, f); end
    run32(3'b011, 32'h80000000, 32'h00000001, lat, busy, r, f);
    total++; if ({r, f} !== {32'h80000001, 4'b1000}) begin bad++; $display("FAIL orr_result: got %h/%b want 80000001/1000", r, f); end
  endtask

  task automatic test_mul();
    int lat, busy; logic [31:0] r; logic [3:0] f;
    run32(3'b101, 32'h00010000, 32'h00010000, lat, busy, r, f);
    total++; if (busy !== 32) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 32", busy); end
    total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency: got %0d want 33", lat); end
    total++; if ({r, f} !== {32'h0, 4'b0100}) begin bad++; $display("FAIL mul_wrap: got %h/%b want 00000000/0100", r, f); end
    run32(3'b101, 32'h0000FFFF, 32'h00000003, lat, busy, r, f);
    total++; if ({r, f} !== {32'h0002FFFD, 4'b0000}) begin bad++; $display("FAIL mul_small: got %h/%b want 0002fffd/0000", r, f); end
  endtask

  task automatic test_shift();
    int lat, busy; logic [31:0] r; logic [3:0] f;
    run32(3'b111, 32'h80000001, 32'h00000001, lat, busy, r, f);
    total++; if (lat !== 2) begin bad++; $display("FAIL lsr_latency: got %0d want 2", lat); end
    total++; if ({r, f} !== {32'h40000000, 4'b0010}) begin bad++; $display("FAIL lsr_result: got %h/%b want 40000000/0010", r, f); end
    run32(3'b110, 32'h00000001, 32'h0000001F, lat, busy, r, f);
    total++; if (lat !== 32) begin bad++; $display("FAIL lsl31_latency: got %0d want 32", lat); end
    total++; if ({r, f} !== {32'h80000000, 4'b1000}) begin bad++; $display("FAIL lsl31_result: got %h/%b want 80000000/1000", r, f); end
    run32(3'b110, 32'h92345678, 32'hFFFFFF00, lat, busy, r, f);
    total++; if (lat !== 1) begin bad++; $display("FAIL lsl0_latency: got %0d want 1", lat); end
    total++; if ({r, f} !== {32'h92345678, 4'b1000}) begin bad++; $display("FAIL lsl0_result: got %h/%b want 92345678/1000", r, f); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    op = 3'b100; a = 32'hFFFF0000; b = 32'h0F0F0F0F; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_handshake[%0d]: got valid=%b ready=%b want 1/0", i, out_valid, in_ready); end
      total++; if ({res, flags} !== {32'hF0F00F0F, 4'b1000}) begin bad++; $display("FAIL bp_hold[%0d]: got %h/%b want f0f00f0f/1000", i, res, flags); end
      op = 3'b000; a = 32'h1; b = 32'h1; in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    total++; if (res !== 32'hF0F00F0F) begin bad++; $display("FAIL bp_result_after: got %h want f0f00f0f", res); end
  endtask

  task automatic test_reset_mid_mul();
    int lat, busy; logic [31:0] r; logic [3:0] f;
    @(negedge clk);
    op = 3'b101; a = 32'h00001234; b = 32'h00005678; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_mul_busy: got in_ready=%b want 0", in_ready); end
    rst = 1'b1;
    #1;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL abort_handshake: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    total++; if ({res, flags} !== 36'h0) begin bad++; $display("FAIL abort_result: got %h/%b want 0/0000", res, flags); end
    @(negedge clk);
    rst = 1'b0;
    run32(3'b000, 32'h2, 32'h3, lat, busy, r, f);
    total++; if ({r, f} !== {32'h5, 4'b0000} || lat !== 1) begin bad++; $display("FAIL after_abort_add: got %h/%b lat=%0d want 00000005/0000 lat=1", r, f, lat); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    @(negedge clk);
    op = 3'b000; a = 32'h1; b = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[3-i] = out_valid;
    end
    in_valid = 1'b0;
    total++; if (seen !== 4'b1010) begin bad++; $display("FAIL b2b_pattern: got %b want 1010", seen); end
    total++; if (res !== 32'h2) begin bad++; $display("FAIL b2b_result: got %h want 00000002", res); end
    @(negedge clk);
  endtask

  // Reference for WIDTH=8, written from the flag definitions
  task automatic model8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] r, output logic [3:0] f, output int lat);
    logic [8:0] w; logic c, v; int n;
    c = 1'b0; v = 1'b0; lat = 1; n = int'(y[2:0]);
    case (o)
      3'b000: begin w = {1'b0, x} + {1'b0, y}; r = w[7:0]; c = w[8]; v = (x[7] == y[7]) && (r[7] != x[7]); end
      3'b001: begin r = x - y; c = (x >= y); v = (x[7] != y[7]) && (r[7] != x[7]); end
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: begin w = 9'(x * y); r = w[7:0]; lat = 9; end
      3'b110: begin r = x << n; if (n > 0) begin c = x[8-n]; lat = n + 1; end end
      default: begin r = x >> n; if (n > 0) begin c = x[n-1]; lat = n + 1; end end
    endcase
    f = {r[7], (r == 8'h0), c, v};
  endtask

  task automatic test_w8();
    int lat, elat; logic [7:0] r, er, x, y; logic [3:0] f, ef; logic [2:0] o;
    run8(3'b000, 8'h7F, 8'h01, lat, r, f);
    total++; if ({r, f} !== {8'h80, 4'b1001}) begin bad++; $display("FAIL w8_add_ovf: got %h/%b want 80/1001", r, f); end
    for (int i = 0; i < 24; i++) begin
      o = 3'(i % 8); x = 8'($urandom); y = 8'($urandom);
      model8(o, x, y, er, ef, elat);
      run8(o, x, y, lat, r, f);
      total++;
      if (r !== er || f !== ef || lat !== elat) begin
        bad++;
        $display("FAIL w8_sweep[%0d] op=%0d a=%h b=%h: got %h/%b lat=%0d want %h/%b lat=%0d", i, o, x, y, r, f, lat, er, ef, elat);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; op = 3'b000; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = 3'b000; a8 = '0; b8 = '0;
    test_reset();
    test_arith();
    test_mul();
    test_shift();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle 32-bit ALU. Same NZCV flag convention; operand width set by WIDTH.
- Opcode widened from 2 to 3 bits. Adds EOR, plus multi-cycle MUL (low half), LSL and LSR.
- Sits between the decode/issue stage and writeback. Holds one operation in flight; valid/ready on both sides.

Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 4.
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation
- ALUControl  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 LSL, 111 LSR
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts, only b[SHW-1:0] is used as the shift amount
- out_valid  output  1  Result and ALUFlags are valid
- out_ready  input  1  consumer accepts the result
- Result  output  WIDTH  result
- ALUFlags  output  4  {N,Z,C,V}

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - State goes to IDLE; counter, operand and accumulator registers go to 0.
  - in_ready = 1, out_valid = 0, Result = 0, ALUFlags = 0.
  - Reset asserted mid-operation aborts it; no result is produced.
- States: IDLE, BUSY, DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- IDLE:
  - Accept when in_valid & in_ready; latch opcode and operands.
  - ADD/SUB/AND/ORR/EOR: compute at the accept edge and go to DONE, so out_valid is high the cycle after accept (latency 1).
  - MUL: go to BUSY with count = WIDTH.
  - LSL/LSR with amount 0: go to DONE; Result = a, C = 0.
  - LSL/LSR with amount > 0: go to BUSY with count = amount.
- BUSY:
  - Each cycle, decrement count.
  - MUL: shift-add step, one multiplier bit per cycle.
  - Shifts: shift by 1 bit; C takes the bit shifted out.
  - When count reaches 0, go to DONE. MUL latency is WIDTH+1 cycles; shift latency is amount+1 cycles.
  - in_valid is ignored while in BUSY.
- DONE:
  - Result and ALUFlags stay stable until out_valid & out_ready, then go to IDLE.
  - A new operation cannot be accepted in the same cycle as the result handshake. Peak throughput is one op per 2 cycles.
- Arithmetic:
  - ADD: {C, sum} = a + b.
  - SUB: {C, diff} = a + ~b + 1; C = 1 means no borrow.
  - V for ADD/SUB: signed overflow, (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]), where b' is the effective second operand.
  - MUL: Result = low WIDTH bits of a*b (unsigned and signed low halves are equal); C = V = 0.
  - AND/ORR/EOR: C = V = 0.
  - LSL/LSR: V = 0; C = last bit shifted out.
- Flags for all ops: N = Result[WIDTH-1]; Z = (Result == 0).
- Result and ALUFlags hold their last value outside DONE. Consumers must qualify them with out_valid.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (3-bit, encodings above).
  - state_t enum {IDLE, BUSY, DONE}.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_core: purely combinational ADD/SUB/AND/ORR/EOR datapath plus NZCV generation, parametrised by WIDTH. seq_alu instantiates it for single-cycle ops and reuses its adder for the MUL accumulate step.

Test Plan:
- ADD, a=FFFFFFFF, b=00000001, out_ready=1 -> out_valid 1 cycle after accept; Result=00000000, ALUFlags=0110.
- SUB, a=7FFFFFFF, b=FFFFFFFF -> Result=80000000, ALUFlags=1001.
- MUL, a=00010000, b=00010000 -> in_ready low for 32 cycles; then Result=00000000, ALUFlags=0100. Also a=0000FFFF, b=00000003 -> Result=0002FFFD, ALUFlags=0000.
- LSR, a=80000001, b=00000001 -> latency 2; Result=40000000, ALUFlags=0010. LSL, a=00000001, b=0000001F -> Result=80000000, ALUFlags=1000, latency 32. LSL with b=0 -> Result=a, C=0, latency 1.
- Backpressure: EOR a=FFFF0000, b=0F0F0F0F with out_ready=0 for 5 cycles -> Result=F0F00F0F and ALUFlags=1000 stable; in_ready=0 throughout; in_valid pulses ignored; IDLE one cycle after out_ready=1.
- Reset mid-MUL (cycle 10 of BUSY) -> out_valid=0, in_ready=1, Result=0, ALUFlags=0 immediately. A following ADD 2+3 completes normally with Result=5.
- Regression sweep: WIDTH=8, random vectors checked against a reference model; ADD 7F+01 -> Result=80, ALUFlags=1001.
